// File: rtl/procyon_dcache_req_arb.sv
// Data cache request arbiter: fills beat LSU requests, one registered request per cycle into D0.
// Optional starvation guard for skidded LSU requests: define PCYN_DC_ARB_STARVE_GUARD_EN.
`ifndef PCYN_LSU_FUNC_WIDTH
`define PCYN_LSU_FUNC_WIDTH 4
`endif

module procyon_dcache_req_arb #(
   parameter int OPTN_DATA_WIDTH      = 32,
   parameter int OPTN_ADDR_WIDTH      = 32,
   parameter int OPTN_DC_CACHE_SIZE   = 1024,
   parameter int OPTN_DC_LINE_SIZE    = 32,
   parameter int OPTN_DC_WAY_COUNT    = 1,
   parameter int OPTN_DC_STARVE_LIMIT = 4,
   parameter int DC_LINE_WIDTH        = OPTN_DC_LINE_SIZE * 8,
   parameter int DC_OFFSET_WIDTH      = $clog2(OPTN_DC_LINE_SIZE),
   parameter int DC_INDEX_WIDTH       = $clog2(OPTN_DC_CACHE_SIZE / OPTN_DC_LINE_SIZE / OPTN_DC_WAY_COUNT),
   parameter int DC_TAG_WIDTH         = OPTN_ADDR_WIDTH - DC_INDEX_WIDTH - DC_OFFSET_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_stall,
   input  logic                            i_lsu_req_valid,
   output logic                            o_lsu_req_ready,
   input  logic                            i_lsu_req_we,
   input  logic [OPTN_ADDR_WIDTH-1:0]      i_lsu_req_addr,
   input  logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_lsu_req_func,
   input  logic [OPTN_DATA_WIDTH-1:0]      i_lsu_req_data,
   input  logic                            i_fill_valid,
   output logic                            o_fill_ready,
   input  logic [OPTN_ADDR_WIDTH-1:0]      i_fill_addr,
   input  logic                            i_fill_dirty,
   input  logic [DC_LINE_WIDTH-1:0]        i_fill_data,
   output logic                            o_req_valid,
   output logic                            o_wr_en,
   output logic                            o_valid,
   output logic                            o_dirty,
   output logic                            o_fill,
   output logic [DC_TAG_WIDTH-1:0]         o_tag,
   output logic [DC_INDEX_WIDTH-1:0]       o_index,
   output logic [DC_OFFSET_WIDTH-1:0]      o_offset,
   output logic [`PCYN_LSU_FUNC_WIDTH-1:0] o_lsu_func,
   output logic [OPTN_DATA_WIDTH-1:0]      o_data,
   output logic [DC_LINE_WIDTH-1:0]        o_fill_data
);

   localparam int FW = `PCYN_LSU_FUNC_WIDTH;

   logic                       skid_full_q, skid_full_d;
   logic                       skid_we_q;
   logic [OPTN_ADDR_WIDTH-1:0] skid_addr_q;
   logic [FW-1:0]              skid_func_q;
   logic [OPTN_DATA_WIDTH-1:0] skid_data_q;

   logic                       starve_grant;
   logic                       issue_fill, issue_skid, issue_lsu;
   logic                       lsu_accept, skid_load;

   logic                       sel_we;
   logic [OPTN_ADDR_WIDTH-1:0] sel_addr;
   logic [FW-1:0]              sel_func;
   logic [OPTN_DATA_WIDTH-1:0] sel_data;

   logic                       req_valid_q, req_valid_d;
   logic                       wr_en_q, wr_en_d;
   logic                       valid_q, valid_d;
   logic                       dirty_q, dirty_d;
   logic                       fill_q, fill_d;
   logic [DC_TAG_WIDTH-1:0]    tag_q, tag_d;
   logic [DC_INDEX_WIDTH-1:0]  index_q, index_d;
   logic [DC_OFFSET_WIDTH-1:0] offset_q, offset_d;
   logic [FW-1:0]              func_q, func_d;
   logic [OPTN_DATA_WIDTH-1:0] data_q, data_d;
   logic [DC_LINE_WIDTH-1:0]   fill_data_q, fill_data_d;

   // Fill line addresses are always installed at offset 0.
   logic unused_fill_offset;
   assign unused_fill_offset = ^i_fill_addr[DC_OFFSET_WIDTH-1:0];

   assign o_lsu_req_ready = ~skid_full_q;
   assign o_fill_ready    = ~i_stall & ~starve_grant;

   assign issue_fill = i_fill_valid & o_fill_ready;
   assign issue_skid = ~i_stall & ~issue_fill & skid_full_q;
   assign issue_lsu  = ~i_stall & ~issue_fill & ~skid_full_q & i_lsu_req_valid;
   assign lsu_accept = i_lsu_req_valid & o_lsu_req_ready;
   assign skid_load  = lsu_accept & ~issue_lsu;

`ifdef PCYN_DC_ARB_STARVE_GUARD_EN
   localparam int CNT_W = (OPTN_DC_STARVE_LIMIT > 0) ? $clog2(OPTN_DC_STARVE_LIMIT + 1) : 1;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign starve_grant = (starve_cnt_q == CNT_W'(OPTN_DC_STARVE_LIMIT));

   // Only fills that overtake a waiting skid entry count toward starvation.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (issue_skid) begin
         starve_cnt_d = '0;
      end else if (issue_fill && skid_full_q) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign starve_grant = 1'b0;
`endif

   always_comb begin
      skid_full_d = skid_full_q;
      if (issue_skid) begin
         skid_full_d = 1'b0;
      end else if (skid_load) begin
         skid_full_d = 1'b1;
      end
   end

   assign sel_we   = skid_full_q ? skid_we_q   : i_lsu_req_we;
   assign sel_addr = skid_full_q ? skid_addr_q : i_lsu_req_addr;
   assign sel_func = skid_full_q ? skid_func_q : i_lsu_req_func;
   assign sel_data = skid_full_q ? skid_data_q : i_lsu_req_data;

   always_comb begin
      req_valid_d = 1'b0;
      wr_en_d     = 1'b0;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      fill_d      = fill_q;
      tag_d       = tag_q;
      index_d     = index_q;
      offset_d    = offset_q;
      func_d      = func_q;
      data_d      = data_q;
      fill_data_d = fill_data_q;
      if (issue_fill) begin
         req_valid_d = 1'b1;
         wr_en_d     = 1'b1;
         valid_d     = 1'b1;
         dirty_d     = i_fill_dirty;
         fill_d      = 1'b1;
         tag_d       = i_fill_addr[OPTN_ADDR_WIDTH-1 -: DC_TAG_WIDTH];
         index_d     = i_fill_addr[DC_OFFSET_WIDTH +: DC_INDEX_WIDTH];
         offset_d    = '0;
         func_d      = '0;
         data_d      = '0;
         fill_data_d = i_fill_data;
      end else if (issue_skid || issue_lsu) begin
         req_valid_d = 1'b1;
         wr_en_d     = sel_we;
         valid_d     = 1'b1;
         dirty_d     = sel_we;
         fill_d      = 1'b0;
         tag_d       = sel_addr[OPTN_ADDR_WIDTH-1 -: DC_TAG_WIDTH];
         index_d     = sel_addr[DC_OFFSET_WIDTH +: DC_INDEX_WIDTH];
         offset_d    = sel_addr[DC_OFFSET_WIDTH-1:0];
         func_d      = sel_func;
         data_d      = sel_data;
         fill_data_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_full_q <= 1'b0;
         req_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         valid_q     <= 1'b0;
         dirty_q     <= 1'b0;
         fill_q      <= 1'b0;
         tag_q       <= '0;
         index_q     <= '0;
         offset_q    <= '0;
         func_q      <= '0;
         data_q      <= '0;
         fill_data_q <= '0;
      end else begin
         skid_full_q <= skid_full_d;
         req_valid_q <= req_valid_d;
         wr_en_q     <= wr_en_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         fill_q      <= fill_d;
         tag_q       <= tag_d;
         index_q     <= index_d;
         offset_q    <= offset_d;
         func_q      <= func_d;
         data_q      <= data_d;
         fill_data_q <= fill_data_d;
      end
   end

   // Skid payload is qualified by skid_full_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_we_q   <= i_lsu_req_we;
         skid_addr_q <= i_lsu_req_addr;
         skid_func_q <= i_lsu_req_func;
         skid_data_q <= i_lsu_req_data;
      end
   end

   assign o_req_valid = req_valid_q;
   assign o_wr_en     = wr_en_q;
   assign o_valid     = valid_q;
   assign o_dirty     = dirty_q;
   assign o_fill      = fill_q;
   assign o_tag       = tag_q;
   assign o_index     = index_q;
   assign o_offset    = offset_q;
   assign o_lsu_func  = func_q;
   assign o_data      = data_q;
   assign o_fill_data = fill_data_q;

endmodule

// File: tb/tb_procyon_dcache_req_arb.sv
// Bench for procyon_dcache_req_arb: directed vector table, starvation/reset sequences, random traffic vs model.
`ifndef PCYN_LSU_FUNC_WIDTH
`define PCYN_LSU_FUNC_WIDTH 4
`endif

module tb_procyon_dcache_req_arb;

   localparam int FW    = `PCYN_LSU_FUNC_WIDTH;
   localparam int LIMIT = 4;
`ifdef PCYN_DC_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_stall = 1'b0;
   logic          i_lsu_req_valid = 1'b0;
   logic          o_lsu_req_ready;
   logic          i_lsu_req_we = 1'b0;
   logic [31:0]   i_lsu_req_addr = '0;
   logic [FW-1:0] i_lsu_req_func = '0;
   logic [31:0]   i_lsu_req_data = '0;
   logic          i_fill_valid = 1'b0;
   logic          o_fill_ready;
   logic [31:0]   i_fill_addr = '0;
   logic          i_fill_dirty = 1'b0;
   logic [255:0]  i_fill_data = '0;
   logic          o_req_valid, o_wr_en, o_valid, o_dirty, o_fill;
   logic [21:0]   o_tag;
   logic [4:0]    o_index, o_offset;
   logic [FW-1:0] o_lsu_func;
   logic [31:0]   o_data;
   logic [255:0]  o_fill_data;

   procyon_dcache_req_arb dut (
      .clk(clk), .rst(rst), .i_stall(i_stall),
      .i_lsu_req_valid(i_lsu_req_valid), .o_lsu_req_ready(o_lsu_req_ready),
      .i_lsu_req_we(i_lsu_req_we), .i_lsu_req_addr(i_lsu_req_addr),
      .i_lsu_req_func(i_lsu_req_func), .i_lsu_req_data(i_lsu_req_data),
      .i_fill_valid(i_fill_valid), .o_fill_ready(o_fill_ready),
      .i_fill_addr(i_fill_addr), .i_fill_dirty(i_fill_dirty), .i_fill_data(i_fill_data),
      .o_req_valid(o_req_valid), .o_wr_en(o_wr_en), .o_valid(o_valid), .o_dirty(o_dirty),
      .o_fill(o_fill), .o_tag(o_tag), .o_index(o_index), .o_offset(o_offset),
      .o_lsu_func(o_lsu_func), .o_data(o_data), .o_fill_data(o_fill_data)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: pending LSU requests held in a queue, outputs recomputed from arbitration rules.
   typedef struct {
      logic          we;
      logic [31:0]   addr;
      logic [FW-1:0] func;
      logic [31:0]   data;
   } lsu_t;

   lsu_t          pend[$];
   int            fills_past = 0;
   logic          e_rv, e_we, e_valid, e_dirty, e_fill;
   logic [21:0]   e_tag;
   logic [4:0]    e_idx, e_off;
   logic [FW-1:0] e_func;
   logic [31:0]   e_data;
   logic [255:0]  e_fdata;
   logic          rd_lrdy, rd_frdy;

   task automatic model_reset();
      pend.delete();
      fills_past = 0;
      e_rv = 0; e_we = 0; e_valid = 0; e_dirty = 0; e_fill = 0;
      e_tag = '0; e_idx = '0; e_off = '0; e_func = '0; e_data = '0; e_fdata = '0;
   endtask

   function automatic bit model_starved();
      return GUARD && (fills_past == LIMIT);
   endfunction

   task automatic model_issue_lsu(input lsu_t r);
      e_rv = 1; e_we = r.we; e_valid = 1; e_dirty = r.we; e_fill = 0;
      e_tag = 22'(r.addr / 1024);
      e_idx = 5'((r.addr / 32) % 32);
      e_off = 5'(r.addr % 32);
      e_func = r.func; e_data = r.data; e_fdata = '0;
   endtask

   task automatic model_step();
      lsu_t cur;
      bit   accepted, issued;
      cur.we = i_lsu_req_we; cur.addr = i_lsu_req_addr;
      cur.func = i_lsu_req_func; cur.data = i_lsu_req_data;
      accepted = i_lsu_req_valid && (pend.size() == 0);
      issued = 0;
      e_rv = 0; e_we = 0;
      if (!i_stall) begin
         if (i_fill_valid && !model_starved()) begin
            e_rv = 1; e_we = 1; e_valid = 1; e_dirty = i_fill_dirty; e_fill = 1;
            e_tag = 22'(i_fill_addr / 1024);
            e_idx = 5'((i_fill_addr / 32) % 32);
            e_off = '0; e_func = '0; e_data = '0; e_fdata = i_fill_data;
            if (GUARD && pend.size() > 0) fills_past++;
         end else if (pend.size() > 0) begin
            model_issue_lsu(pend.pop_front());
            fills_past = 0;
         end else if (i_lsu_req_valid) begin
            model_issue_lsu(cur);
            issued = 1;
         end
      end
      if (accepted && !issued) pend.push_back(cur);
   endtask

   task automatic cycle();
      #2;
      rd_lrdy = o_lsu_req_ready;
      rd_frdy = o_fill_ready;
      chk("lsu_ready", 256'(rd_lrdy), 256'(pend.size() == 0));
      chk("fill_ready", 256'(rd_frdy), 256'(!i_stall && !model_starved()));
      model_step();
      @(posedge clk);
      #1;
      chk("req_valid", 256'(o_req_valid), 256'(e_rv));
      chk("wr_en", 256'(o_wr_en), 256'(e_we));
      chk("ctl_valid_dirty_fill", 256'({o_valid, o_dirty, o_fill}), 256'({e_valid, e_dirty, e_fill}));
      chk("tag_idx_off", 256'({o_tag, o_index, o_offset}), 256'({e_tag, e_idx, e_off}));
      chk("lsu_func", 256'(o_lsu_func), 256'(e_func));
      chk("data", 256'(o_data), 256'(e_data));
      chk("fill_data", o_fill_data, e_fdata);
   endtask

   task automatic set_in(input bit st, input bit fv, input logic [31:0] fa, input bit fd,
                         input bit lv, input bit we, input logic [31:0] a,
                         input logic [FW-1:0] fn, input logic [31:0] d);
      i_stall = st; i_fill_valid = fv; i_fill_addr = fa; i_fill_dirty = fd;
      i_lsu_req_valid = lv; i_lsu_req_we = we; i_lsu_req_addr = a;
      i_lsu_req_func = fn; i_lsu_req_data = d;
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, 256'({o_req_valid, o_wr_en, o_valid, o_dirty, o_fill, o_tag, o_index, o_offset,
                    o_lsu_func, o_data}), 256'(0));
      chk({nm, "_fill_data"}, o_fill_data, 256'(0));
   endtask

   typedef struct {
      bit          st, fv;
      logic [31:0] fa;
      bit          fd, lv, we;
      logic [31:0] a;
      logic [3:0]  fn;
      logic [31:0] d;
      bit          x_lrdy, x_frdy, x_rv, x_we, x_fill, x_dirty;
      logic [21:0] x_tag;
      logic [4:0]  x_idx, x_off;
      logic [3:0]  x_fn;
      logic [31:0] x_d;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int first_lsu;
      bit slot_frdy;

      tbl[0]  = '{0,0,32'h0,0, 1,0,32'h0000_1234,4'd2,32'h1111_1111, 1,1, 1,0,0,0, 22'h4,5'h11,5'h14,4'd2,32'h1111_1111};
      tbl[1]  = '{0,1,32'h0000_2000,0, 1,1,32'h40,4'd3,32'hDEAD_BEEF, 1,1, 1,1,1,0, 22'h8,5'h0,5'h0,4'd0,32'h0};
      tbl[2]  = '{0,0,32'h0,0, 0,0,32'h0,4'd0,32'h0, 0,1, 1,1,0,1, 22'h0,5'h2,5'h0,4'd3,32'hDEAD_BEEF};
      tbl[3]  = '{1,0,32'h0,0, 1,0,32'h80,4'd2,32'h5555, 1,0, 0,0,0,1, 22'h0,5'h2,5'h0,4'd3,32'hDEAD_BEEF};
      tbl[4]  = '{1,0,32'h0,0, 1,0,32'h80,4'd2,32'h5555, 0,0, 0,0,0,1, 22'h0,5'h2,5'h0,4'd3,32'hDEAD_BEEF};
      tbl[5]  = '{1,0,32'h0,0, 1,0,32'h80,4'd2,32'h5555, 0,0, 0,0,0,1, 22'h0,5'h2,5'h0,4'd3,32'hDEAD_BEEF};
      tbl[6]  = '{0,0,32'h0,0, 0,0,32'h0,4'd0,32'h0, 0,1, 1,0,0,0, 22'h0,5'h4,5'h0,4'd2,32'h5555};
      tbl[7]  = '{0,0,32'h0,0, 1,1,32'h3FF,4'd3,32'hA5A5_A5A5, 1,1, 1,1,0,1, 22'h0,5'h1F,5'h1F,4'd3,32'hA5A5_A5A5};
      tbl[8]  = '{0,0,32'h0,0, 1,0,32'hFFFF_FFE0,4'd2,32'h1234_5678, 1,1, 1,0,0,0, 22'h3F_FFFF,5'h1F,5'h0,4'd2,32'h1234_5678};
      tbl[9]  = '{0,1,32'h1234_567F,1, 0,0,32'h0,4'd0,32'h0, 1,1, 1,1,1,1, 22'h4_8D15,5'h13,5'h0,4'd0,32'h0};
      tbl[10] = '{0,0,32'h0,0, 0,0,32'h0,4'd0,32'h0, 1,1, 0,0,1,1, 22'h4_8D15,5'h13,5'h0,4'd0,32'h0};

      model_reset();
      i_fill_data = {8{32'hC0DE_0001}};
      #1 rst = 1'b1;
      #1;
      chk_all_zero("reset_outputs");
      chk("reset_lsu_ready", 256'(o_lsu_req_ready), 256'(1));
      chk("reset_fill_ready", 256'(o_fill_ready), 256'(1));
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         set_in(tbl[i].st, tbl[i].fv, tbl[i].fa, tbl[i].fd, tbl[i].lv, tbl[i].we,
                tbl[i].a, FW'(tbl[i].fn), tbl[i].d);
         cycle();
         chk($sformatf("vec%0d_ready", i), 256'({rd_lrdy, rd_frdy}), 256'({tbl[i].x_lrdy, tbl[i].x_frdy}));
         chk($sformatf("vec%0d_ctl", i), 256'({o_req_valid, o_wr_en, o_fill, o_dirty}),
             256'({tbl[i].x_rv, tbl[i].x_we, tbl[i].x_fill, tbl[i].x_dirty}));
         chk($sformatf("vec%0d_addr", i), 256'({o_tag, o_index, o_offset}),
             256'({tbl[i].x_tag, tbl[i].x_idx, tbl[i].x_off}));
         chk($sformatf("vec%0d_func_data", i), 256'({o_lsu_func, o_data}),
             256'({FW'(tbl[i].x_fn), tbl[i].x_d}));
      end

      // Skid fills up behind a fill, then fills keep arriving back to back.
      set_in(0, 1, 32'h3000, 0, 1, 1, 32'h60, FW'(3), 32'hFEED_0060);
      cycle();
      first_lsu = -1;
      slot_frdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_in(0, 1, 32'h4000 + 32'(k * 32), 1, 0, 0, 32'h0, '0, 32'h0);
         cycle();
         if (first_lsu < 0 && o_req_valid && !o_fill) begin
            first_lsu = k;
            slot_frdy = rd_frdy;
         end
      end
      chk("starve_slot", 256'(first_lsu), GUARD ? 256'(LIMIT) : 256'(-1));
      if (GUARD) chk("starve_fill_ready", 256'(slot_frdy), 256'(0));
      set_in(0, 0, 32'h0, 0, 0, 0, 32'h0, '0, 32'h0);
      cycle();
      chk("after_fills_rv", 256'(o_req_valid), GUARD ? 256'(0) : 256'(1));
      if (!GUARD) chk("after_fills_store", 256'({o_wr_en, o_fill, o_index}), 256'({1'b1, 1'b0, 5'h3}));

      for (int n = 0; n < 1500; n++) begin
         set_in(($urandom % 4) == 0, ($urandom % 3) == 0, $urandom, 1'($urandom),
                1'($urandom), 1'($urandom), $urandom, FW'($urandom), $urandom);
         i_fill_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         cycle();
      end

      // Reset in the middle of traffic with a request parked in the skid.
      set_in(0, 0, 32'h0, 0, 1, 1, 32'h0000_ABCD, FW'(5), 32'h7777_7777);
      cycle();
      set_in(1, 0, 32'h0, 0, 1, 0, 32'h0000_0100, FW'(2), 32'h0101_0101);
      cycle();
      chk("pre_reset_skid_full", 256'(pend.size() != 0 || rd_lrdy == 1'b0), 256'(1));
      #3 rst = 1'b1;
      #1;
      chk_all_zero("midreset_outputs");
      chk("midreset_lsu_ready", 256'(o_lsu_req_ready), 256'(1));
      chk("midreset_fill_ready_stalled", 256'(o_fill_ready), 256'(0));
      i_stall = 1'b0;
      #1;
      chk("midreset_fill_ready", 256'(o_fill_ready), 256'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      set_in(0, 0, 32'h0, 0, 0, 0, 32'h0, '0, 32'h0);
      cycle();
      chk("skid_discarded", 256'(o_req_valid), 256'(0));
      cycle();
      chk("skid_still_empty", 256'(o_req_valid), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
